// File: rtl/nn_stim_tx_if.sv
// Signal bundle between nn_stim_tx, its stimulus RAM and the NN core.
// The master modport is the transmitter side; slave is the RAM/NN/controller side.
interface nn_stim_tx_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [7:0]        num_samples;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              in_valid_w1;
    logic              in_valid_w2;
    logic              in_valid_d;
    logic              in_valid_t;
    logic [DATA_W-1:0] weight1;
    logic [DATA_W-1:0] weight2;
    logic [DATA_W-1:0] data_point;
    logic [DATA_W-1:0] target;
    logic              out_valid;
    logic [DATA_W-1:0] out;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [7:0]        res_idx;

    modport master (
        input  start, num_samples, mem_rdata, out_valid, out,
        output busy, done, err, mem_rd, mem_addr,
        output in_valid_w1, in_valid_w2, in_valid_d, in_valid_t,
        output weight1, weight2, data_point, target,
        output res_valid, res_data, res_idx
    );

    modport slave (
        output start, num_samples, mem_rdata, out_valid, out,
        input  busy, done, err, mem_rd, mem_addr,
        input  in_valid_w1, in_valid_w2, in_valid_d, in_valid_t,
        input  weight1, weight2, data_point, target,
        input  res_valid, res_data, res_idx
    );
endinterface

// File: rtl/nn_stim_tx.sv
// Streams weights and samples from a synchronous stimulus RAM into the NN core
// and returns each NN result tagged with its sample index.
module nn_stim_tx #(
    parameter int DATA_W  = 32,
    parameter int IN_DIM  = 4,
    parameter int L1_DIM  = 3,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 1000
) (
    input logic         clk,
    input logic         rst,
    nn_stim_tx_if.master bus
);
    localparam int W1_NUM   = IN_DIM * L1_DIM;
    localparam int W2_NUM   = L1_DIM;
    localparam int CNT_MAX0 = (TIMEOUT > W1_NUM) ? TIMEOUT : W1_NUM;
    localparam int CNT_MAX  = (CNT_MAX0 > W2_NUM + 2) ? CNT_MAX0 : W2_NUM + 2;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] W1_LAST = CNT_W'(W1_NUM - 1);
    localparam logic [CNT_W-1:0] W2_LAST = CNT_W'(W2_NUM - 1);
    localparam logic [CNT_W-1:0] W2_DONE = CNT_W'(W2_NUM + 1);
    localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(IN_DIM - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_W1, S_W2, S_DATA, S_TGT, S_WAIT} state_t;
    typedef enum logic [1:0] {K_W1, K_W2, K_D, K_T} kind_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         num_q, num_d;
    logic [7:0]         smp_q, smp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               res_vld_q, res_vld_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic [7:0]         res_idx_q, res_idx_d;

    // p0: address issue, p1: RAM access in flight, p2: word on the NN bus
    logic               rd_p0_q, rd_p0_d;
    logic [ADDR_W-1:0]  addr_p0_q, addr_p0_d;
    kind_t              kind_p0_q, kind_p0_d;
    logic               vld_p1_q;
    kind_t              kind_p1_q;
    logic [3:0]         strb_p2_q, strb_p2_d;
    logic [DATA_W-1:0]  w1_p2_q, w1_p2_d;
    logic [DATA_W-1:0]  w2_p2_q, w2_p2_d;
    logic [DATA_W-1:0]  dp_p2_q, dp_p2_d;
    logic [DATA_W-1:0]  tg_p2_q, tg_p2_d;

    // FSM state register and control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            num_q      <= '0;
            smp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_idx_q  <= '0;
            rd_p0_q    <= 1'b0;
            addr_p0_q  <= '0;
            kind_p0_q  <= K_W1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            smp_q      <= smp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
            rd_p0_q    <= rd_p0_d;
            addr_p0_q  <= addr_p0_d;
            kind_p0_q  <= kind_p0_d;
        end
    end

    // The state names the phase whose addresses are being issued; the W2 and
    // TGT phases linger a few cycles after their last read so done and the
    // first WAIT cycle line up with the words actually reaching the NN.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        smp_d      = smp_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        res_vld_d  = 1'b0;
        res_data_d = '0;
        res_idx_d  = '0;
        rd_p0_d    = 1'b0;
        addr_p0_d  = addr_p0_q;
        kind_p0_d  = kind_p0_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_W1;
                    cnt_d     = '0;
                    num_d     = bus.num_samples;
                    smp_d     = '0;
                    rd_p0_d   = 1'b1;
                    addr_p0_d = '0;
                    kind_p0_d = K_W1;
                end
            end
            S_W1: begin
                rd_p0_d   = 1'b1;
                addr_p0_d = addr_p0_q + ADDR_W'(1);
                if (cnt_q == W1_LAST) begin
                    state_d   = S_W2;
                    cnt_d     = '0;
                    kind_p0_d = K_W2;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    kind_p0_d = K_W1;
                end
            end
            S_W2: begin
                if (cnt_q < W2_LAST) begin
                    rd_p0_d   = 1'b1;
                    addr_p0_d = addr_p0_q + ADDR_W'(1);
                    kind_p0_d = K_W2;
                    cnt_d     = cnt_q + CNT_ONE;
                end else if (cnt_q == W2_LAST && num_q != 8'd0) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    rd_p0_d   = 1'b1;
                    addr_p0_d = addr_p0_q + ADDR_W'(1);
                    kind_p0_d = K_D;
                end else if (cnt_q == W2_DONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                rd_p0_d   = 1'b1;
                addr_p0_d = addr_p0_q + ADDR_W'(1);
                if (cnt_q == D_LAST) begin
                    state_d   = S_TGT;
                    cnt_d     = '0;
                    kind_p0_d = K_T;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    kind_p0_d = K_D;
                end
            end
            S_TGT: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_ONE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (bus.out_valid) begin
                    res_vld_d  = 1'b1;
                    res_data_d = bus.out;
                    res_idx_d  = smp_q;
                    smp_d      = smp_q + 8'd1;
                    cnt_d      = '0;
                    if (smp_q + 8'd1 == num_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_DATA;
                        rd_p0_d   = 1'b1;
                        addr_p0_d = addr_p0_q + ADDR_W'(1);
                        kind_p0_d = K_D;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Tag travels with the RAM access so the returning word lands on the right bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            kind_p1_q <= K_W1;
            strb_p2_q <= '0;
            w1_p2_q   <= '0;
            w2_p2_q   <= '0;
            dp_p2_q   <= '0;
            tg_p2_q   <= '0;
        end else begin
            vld_p1_q  <= rd_p0_q;
            kind_p1_q <= kind_p0_q;
            strb_p2_q <= strb_p2_d;
            w1_p2_q   <= w1_p2_d;
            w2_p2_q   <= w2_p2_d;
            dp_p2_q   <= dp_p2_d;
            tg_p2_q   <= tg_p2_d;
        end
    end

    always_comb begin
        strb_p2_d    = '0;
        strb_p2_d[3] = vld_p1_q && (kind_p1_q == K_W1);
        strb_p2_d[2] = vld_p1_q && (kind_p1_q == K_W2);
        strb_p2_d[1] = vld_p1_q && (kind_p1_q == K_D);
        strb_p2_d[0] = vld_p1_q && (kind_p1_q == K_T);
        w1_p2_d      = strb_p2_d[3] ? bus.mem_rdata : '0;
        w2_p2_d      = strb_p2_d[2] ? bus.mem_rdata : '0;
        dp_p2_d      = strb_p2_d[1] ? bus.mem_rdata : '0;
        tg_p2_d      = strb_p2_d[0] ? bus.mem_rdata : '0;
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.mem_rd      = rd_p0_q;
    assign bus.mem_addr    = addr_p0_q;
    assign bus.in_valid_w1 = strb_p2_q[3];
    assign bus.in_valid_w2 = strb_p2_q[2];
    assign bus.in_valid_d  = strb_p2_q[1];
    assign bus.in_valid_t  = strb_p2_q[0];
    assign bus.weight1     = w1_p2_q;
    assign bus.weight2     = w2_p2_q;
    assign bus.data_point  = dp_p2_q;
    assign bus.target      = tg_p2_q;
    assign bus.res_valid   = res_vld_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_idx     = res_idx_q;
endmodule
